// File: rtl/uart_bus_arb.sv
// uart_bus_arb: two-master arbiter in front of a single UART peripheral port.
// One transaction is outstanding at a time. An IDLE cycle picks the winner, ADDR
// forwards the request until the slave grants it, and RESP waits for the response
// or for a timeout.
//
// Ports:
//   clk, resetn             clock; synchronous active-low reset
//   mX_req/addr/we/be/wdata master request and payload (X = 0, 1)
//   mX_gnt, mX_rvalid       per-master grant (combinational) and response strobe
//   m_rdata, m_err          shared response data/error, qualified by mX_rvalid
//   s_req/addr/we/be/wdata  slave-side request; driven only in ADDR
//   s_gnt/rvalid/rdata/err  slave-side grant and response
//   busy                    a transaction is in flight (ADDR or RESP)
//   stray_rvalid            sticky flag: slave responded with nothing outstanding
module uart_bus_arb #(
    parameter int unsigned TIMEOUT    = 15,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,

    output logic [31:0] m_rdata,
    output logic        m_err,

    output logic        s_req,
    output logic [31:0] s_addr,
    output logic        s_we,
    output logic [3:0]  s_be,
    output logic [31:0] s_wdata,
    input  logic        s_gnt,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    input  logic        s_err,

    output logic        busy,
    output logic        stray_rvalid
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             winner, winner_nxt;         // 0 = m0, 1 = m1
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             stray_nxt;
    // A transaction dropped by reset may still be answered by the slave; that one
    // late response must not be flagged as stray.
    logic             drop_pending, drop_pending_nxt;
    logic             pick;

    // Arbitration: single requester wins; ties go to m0 (fixed) or away from last_grant.
    always_comb begin
        pick = 1'b0;
        if (m0_req && m1_req) begin
            pick = FIXED_PRIO ? 1'b0 : ~last_grant;
        end else begin
            pick = m1_req;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            winner       <= 1'b0;
            last_grant   <= 1'b1;
            count        <= '0;
            stray_rvalid <= 1'b0;
            drop_pending <= (state != IDLE);
        end else begin
            state        <= state_nxt;
            winner       <= winner_nxt;
            last_grant   <= last_grant_nxt;
            count        <= count_nxt;
            stray_rvalid <= stray_nxt;
            drop_pending <= drop_pending_nxt;
        end
    end

    // Next state and combinational outputs.
    always_comb begin
        state_nxt        = state;
        winner_nxt       = winner;
        last_grant_nxt   = last_grant;
        count_nxt        = count;
        stray_nxt        = stray_rvalid;
        drop_pending_nxt = drop_pending;

        busy      = 1'b0;
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        m0_rvalid = 1'b0;
        m1_rvalid = 1'b0;
        m_rdata   = '0;
        m_err     = 1'b0;
        s_req     = 1'b0;
        s_addr    = '0;
        s_we      = 1'b0;
        s_be      = '0;
        s_wdata   = '0;

        // Responses outside RESP never reach the masters.
        if (s_rvalid && (state != RESP)) begin
            if (drop_pending) begin
                drop_pending_nxt = 1'b0;
            end else begin
                stray_nxt = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    winner_nxt = pick;
                    state_nxt  = ADDR;
                end
            end

            ADDR: begin
                busy    = 1'b1;
                s_req   = 1'b1;
                s_addr  = winner ? m1_addr  : m0_addr;
                s_we    = winner ? m1_we    : m0_we;
                s_be    = winner ? m1_be    : m0_be;
                s_wdata = winner ? m1_wdata : m0_wdata;
                if (s_gnt) begin
                    m0_gnt           = ~winner;
                    m1_gnt           = winner;
                    count_nxt        = '0;
                    drop_pending_nxt = 1'b0;
                    state_nxt        = RESP;
                end
            end

            RESP: begin
                busy = 1'b1;
                // A real response takes precedence over a coincident timeout.
                if (s_rvalid || (count == TIMEOUT_CNT)) begin
                    m0_rvalid      = ~winner;
                    m1_rvalid      = winner;
                    m_rdata        = s_rvalid ? s_rdata : 32'h0;
                    m_err          = s_rvalid ? s_err : 1'b1;
                    last_grant_nxt = winner;
                    count_nxt      = '0;
                    state_nxt      = IDLE;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
